// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// opcode map, unit indices, one-hot register encodings and the opcode decoder.
package seq_pkg;

  localparam int unsigned NUM_UNITS   = 4;
  localparam int unsigned WDOG_CYCLES = 16;
  localparam int unsigned UNIT_IDX_W  = $clog2(NUM_UNITS);
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned OPC_W       = 4;
  localparam int unsigned PARAM_W     = 6;
  localparam int unsigned REG_EN_W    = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned WDOG_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_RETIRE,
    ST_FAULT
  } seq_state_e;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'h4;
  localparam logic [OPC_W-1:0] OP_LOAD = 4'h8;

  localparam logic [UNIT_IDX_W-1:0] UNIT_MOV  = 2'd0;
  localparam logic [UNIT_IDX_W-1:0] UNIT_ADD  = 2'd1;
  localparam logic [UNIT_IDX_W-1:0] UNIT_SUB  = 2'd2;
  localparam logic [UNIT_IDX_W-1:0] UNIT_LOAD = 2'd3;

  localparam logic [REG_EN_W-1:0] REG_R0 = 4'b1000;
  localparam logic [REG_EN_W-1:0] REG_R1 = 4'b0100;
  localparam logic [REG_EN_W-1:0] REG_R2 = 4'b0010;
  localparam logic [REG_EN_W-1:0] REG_R3 = 4'b0001;

  typedef enum logic [1:0] {
    OPK_NOP,
    OPK_UNIT,
    OPK_ILLEGAL
  } op_kind_e;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [PARAM_W-1:0] param1;
    logic [PARAM_W-1:0] param2;
  } instr_t;

  typedef struct packed {
    op_kind_e              kind;
    logic [UNIT_IDX_W-1:0] unit;
  } op_decode_t;

  // Classify an opcode and pick the execution unit that owns it
  function automatic op_decode_t decode_op(input logic [OPC_W-1:0] op);
    op_decode_t d;
    d.kind = OPK_ILLEGAL;
    d.unit = '0;
    case (op)
      OP_NOP:  d.kind = OPK_NOP;
      OP_MOV:  begin d.kind = OPK_UNIT; d.unit = UNIT_MOV;  end
      OP_ADD:  begin d.kind = OPK_UNIT; d.unit = UNIT_ADD;  end
      OP_SUB:  begin d.kind = OPK_UNIT; d.unit = UNIT_SUB;  end
      OP_LOAD: begin d.kind = OPK_UNIT; d.unit = UNIT_LOAD; end
      default: d.kind = OPK_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction handshake, unit side-band and shared register-enable bus.
// slave: sequencer view; master: instruction source / unit / register-file view.
interface instr_sequencer_if;
  import seq_pkg::*;

  logic                          instr_valid;
  logic [INSTR_W-1:0]            instruction;
  logic                          instr_ready;
  logic [INSTR_W-1:0]            instr_out;
  logic [NUM_UNITS-1:0]          unit_done;
  logic [NUM_UNITS*REG_EN_W-1:0] unit_rxOut;
  logic [NUM_UNITS*REG_EN_W-1:0] unit_rxIn;
  logic [NUM_UNITS-1:0]          unit_pcInc;
  logic [REG_EN_W-1:0]           rxOut;
  logic [REG_EN_W-1:0]           rxIn;
  logic                          pcInc;
  logic                          busy;
  logic                          retired;
  logic                          illegal;
  logic                          fault;
  logic [CNT_W-1:0]              retire_cnt;

  modport slave (
    input  instr_valid, instruction, unit_done, unit_rxOut, unit_rxIn, unit_pcInc,
    output instr_ready, instr_out, rxOut, rxIn, pcInc, busy, retired, illegal,
           fault, retire_cnt
  );

  modport master (
    output instr_valid, instruction, unit_done, unit_rxOut, unit_rxIn, unit_pcInc,
    input  instr_ready, instr_out, rxOut, rxIn, pcInc, busy, retired, illegal,
           fault, retire_cnt
  );
endinterface

// File: rtl/seq_watchdog.sv
// Counts consecutive WAIT cycles and flags expiry on the cycle the count
// reaches LIMIT. Counter is held at zero outside WAIT, so it clears on entry.
module seq_watchdog
  import seq_pkg::*;
#(
  parameter int unsigned LIMIT = WDOG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expire_o
);

  logic [WDOG_CNT_W-1:0] cnt_q;
  logic [WDOG_CNT_W-1:0] cnt_d;

  // Next count: advance while waiting, clear otherwise
  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + WDOG_CNT_W'(1);
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = run_i && (cnt_d == WDOG_CNT_W'(LIMIT));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction, routes it to its execution
// unit, hands that unit the shared register enables and pcInc while it runs,
// and retires it on the unit's done pulse.
// Optional feature: define SEQ_WATCHDOG_EN to add a WAIT-state watchdog that
// aborts to FAULT after WDOG_CYCLES cycles without done.
module instr_sequencer
  import seq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

  seq_state_e            state_q;
  instr_t                instr_reg_q;
  logic [UNIT_IDX_W-1:0] active_q;
  logic [INSTR_W-1:0]    instr_out_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  retired_q;
  logic                  illegal_q;
  logic [CNT_W-1:0]      retire_cnt_q;

  op_decode_t            in_dec_c;
  op_decode_t            reg_dec_c;
  logic                  in_wait_c;
  logic                  done_sel_c;
  logic                  wdog_expire_c;

  logic [REG_EN_W-1:0]   rx_out_sl [NUM_UNITS];
  logic [REG_EN_W-1:0]   rx_in_sl  [NUM_UNITS];

  assign in_dec_c   = decode_op(bus.instruction[INSTR_W-1 -: OPC_W]);
  assign reg_dec_c  = decode_op(instr_reg_q.opcode);
  assign in_wait_c  = (state_q == ST_WAIT);
  assign done_sel_c = bus.unit_done[active_q];

  // Split the flat per-unit enable buses into one slice per unit
  always_comb begin
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      rx_out_sl[i] = bus.unit_rxOut[i*REG_EN_W +: REG_EN_W];
      rx_in_sl[i]  = bus.unit_rxIn[i*REG_EN_W +: REG_EN_W];
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic fault_q;

  seq_watchdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (in_wait_c),
    .expire_o (wdog_expire_c)
  );

  assign bus.fault = fault_q;
`else
  assign wdog_expire_c = 1'b0;
  assign bus.fault     = 1'b0;
`endif

  // Sequencer FSM with registered status and broadcast outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_reg_q  <= '0;
      active_q     <= '0;
      instr_out_q  <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      retired_q    <= 1'b0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      fault_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            instr_reg_q <= instr_t'(bus.instruction);
            state_q     <= ST_DECODE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            illegal_q   <= (in_dec_c.kind == OPK_ILLEGAL);
          end
        end
        ST_DECODE: begin
          case (reg_dec_c.kind)
            OPK_UNIT: begin
              state_q     <= ST_WAIT;
              active_q    <= reg_dec_c.unit;
              instr_out_q <= instr_reg_q;
            end
            OPK_NOP: begin
              state_q      <= ST_RETIRE;
              retired_q    <= 1'b1;
              retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
            default: begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
        ST_WAIT: begin
          // done takes priority over a simultaneous watchdog expiry
          if (done_sel_c) begin
            state_q      <= ST_RETIRE;
            retired_q    <= 1'b1;
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            instr_out_q  <= '0;
          end else if (wdog_expire_c) begin
            state_q     <= ST_FAULT;
            instr_out_q <= '0;
`ifdef SEQ_WATCHDOG_EN
            fault_q     <= 1'b1;
`endif
          end
        end
        ST_RETIRE, ST_FAULT: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.retired     = retired_q;
  assign bus.illegal     = illegal_q;
  assign bus.retire_cnt  = retire_cnt_q;
  assign bus.instr_out   = instr_out_q;

  // Only the active unit owns the shared enables, and only while in WAIT
  assign bus.rxOut = in_wait_c ? rx_out_sl[active_q] : '0;
  assign bus.rxIn  = in_wait_c ? rx_in_sl[active_q]  : '0;
  assign bus.pcInc = in_wait_c ? bus.unit_pcInc[active_q] : 1'b0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: randomized instructions and unit
// activity checked against an opcode-table reference model.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned model_cnt = 0;
  int unit_map [16];  // -1 illegal, -2 NOP, else unit index

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_units();
    bus.unit_done  = '0;
    bus.unit_rxOut = '0;
    bus.unit_rxIn  = '0;
    bus.unit_pcInc = '0;
  endtask

  task automatic issue(input logic [15:0] instr);
    int guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: instr_ready=%b required 1", bus.instr_ready);
    end
    bus.instruction = instr;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = 16'h4043;
    bus.unit_done  = 4'hF;
    bus.unit_rxOut = 16'($urandom);
    bus.unit_rxIn  = 16'($urandom);
    bus.unit_pcInc = 4'hF;
    tick();
    tick();
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: ready=%b busy=%b required 1 0", bus.instr_ready, bus.busy);
    end
    n_checks++;
    if (bus.instr_out !== 16'h0 || bus.retire_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: instr_out=%h cnt=%h required 0 0", bus.instr_out, bus.retire_cnt);
    end
    n_checks++;
    if ({bus.retired, bus.illegal, bus.fault} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: ret/ill/flt=%b required 000", {bus.retired, bus.illegal, bus.fault});
    end
    n_checks++;
    if ({bus.rxOut, bus.rxIn, bus.pcInc} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_bus: rxOut=%b rxIn=%b pcInc=%b required 0", bus.rxOut, bus.rxIn, bus.pcInc);
    end
    quiet_units();
    rst = 1'b0;
    model_cnt = 0;
    tick();
  endtask

  task automatic test_mov();
    logic [15:0] r;
    issue(16'h4043);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.instr_ready !== 1'b0 || bus.instr_out !== 16'h0) begin
      n_fail++;
      $display("FAIL mov_decode: busy=%b ready=%b out=%h required 1 0 0000", bus.busy, bus.instr_ready, bus.instr_out);
    end
    // an offered instruction while busy must be ignored
    bus.instruction = 16'h1fff;
    bus.instr_valid = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_out !== 16'h4043) begin
      n_fail++;
      $display("FAIL mov_out: instr_out=%h required 4043", bus.instr_out);
    end
    r = 16'($urandom);
    bus.unit_rxOut = {r[15:4], REG_R3};
    #1;
    n_checks++;
    if (bus.rxOut !== 4'b0001) begin
      n_fail++;
      $display("FAIL mov_rxout: rxOut=%b required 0001", bus.rxOut);
    end
    tick();
    bus.unit_rxOut = {r[15:4], 4'b0000};
    bus.unit_rxIn  = {r[11:0], REG_R1};
    bus.unit_pcInc = 4'b1111;
    #1;
    n_checks++;
    if (bus.rxIn !== 4'b0100 || bus.rxOut !== 4'b0000 || bus.pcInc !== 1'b1) begin
      n_fail++;
      $display("FAIL mov_rxin: rxIn=%b rxOut=%b pcInc=%b required 0100 0000 1", bus.rxIn, bus.rxOut, bus.pcInc);
    end
    n_checks++;
    if (bus.instr_out !== 16'h4043) begin
      n_fail++;
      $display("FAIL mov_hold: instr_out=%h required 4043", bus.instr_out);
    end
    bus.instr_valid = 1'b0;
    bus.unit_done = 4'b0001;
    tick();
    n_checks++;
    if (bus.retired !== 1'b1 || bus.instr_out !== 16'h0 || bus.rxIn !== 4'h0) begin
      n_fail++;
      $display("FAIL mov_retire: retired=%b out=%h rxIn=%b required 1 0000 0000", bus.retired, bus.instr_out, bus.rxIn);
    end
    model_cnt = (model_cnt + 1) % 65536;
    quiet_units();
    tick();
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.retired !== 1'b0 || bus.retire_cnt !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL mov_idle: ready=%b retired=%b cnt=%h required 1 0 %h", bus.instr_ready, bus.retired, bus.retire_cnt, 16'(model_cnt));
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] op;
      logic [15:0] ins;
      do op = 4'($urandom); while (unit_map[op] != -1);
      if (k == 0) op = 4'h7;
      ins = {op, 12'($urandom)};
      issue(ins);
      n_checks++;
      if (bus.illegal !== 1'b1 || bus.instr_out !== 16'h0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_pulse: op=%h illegal=%b out=%h busy=%b required 1 0000 1", op, bus.illegal, bus.instr_out, bus.busy);
      end
      tick();
      n_checks++;
      if (bus.illegal !== 1'b0 || bus.instr_ready !== 1'b1 || bus.retire_cnt !== 16'(model_cnt) || bus.instr_out !== 16'h0) begin
        n_fail++;
        $display("FAIL illegal_idle: illegal=%b ready=%b cnt=%h out=%h required 0 1 %h 0000", bus.illegal, bus.instr_ready, bus.retire_cnt, bus.instr_out, 16'(model_cnt));
      end
    end
  endtask

  // Random mix of unit, NOP and illegal instructions with random unit traffic
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ins;
      int u;
      int lat;
      ins = 16'($urandom);
      if (($urandom % 4) != 0) begin
        case ($urandom % 5)
          0: ins[15:12] = 4'h4;
          1: ins[15:12] = 4'h1;
          2: ins[15:12] = 4'h2;
          3: ins[15:12] = 4'h8;
          default: ins[15:12] = 4'h0;
        endcase
      end
      u = unit_map[ins[15:12]];
      issue(ins);
      n_checks++;
      if (bus.illegal !== (u == -1)) begin
        n_fail++;
        $display("FAIL rnd_illegal: ins=%h illegal=%b required %b", ins, bus.illegal, (u == -1));
      end
      if (u == -1) begin
        tick();
      end else if (u == -2) begin
        tick();
        model_cnt = (model_cnt + 1) % 65536;
        n_checks++;
        if (bus.retired !== 1'b1 || bus.instr_out !== 16'h0) begin
          n_fail++;
          $display("FAIL rnd_nop: retired=%b out=%h required 1 0000", bus.retired, bus.instr_out);
        end
        tick();
      end else begin
        tick();
        lat = $urandom_range(0, 5);
        for (int c = 0; c <= lat; c++) begin
          logic [15:0] ro, ri;
          logic [3:0] pc, dn;
          ro = 16'($urandom);
          ri = 16'($urandom);
          pc = 4'($urandom);
          dn = 4'($urandom);
          dn[u] = (c == lat);
          bus.unit_rxOut = ro;
          bus.unit_rxIn  = ri;
          bus.unit_pcInc = pc;
          bus.unit_done  = dn;
          #1;
          n_checks++;
          if (bus.rxOut !== ro[4*u +: 4] || bus.rxIn !== ri[4*u +: 4] || bus.pcInc !== pc[u] || bus.instr_out !== ins) begin
            n_fail++;
            $display("FAIL rnd_fwd: u=%0d rxOut=%b rxIn=%b pc=%b out=%h required %b %b %b %h", u, bus.rxOut, bus.rxIn, bus.pcInc, bus.instr_out, ro[4*u +: 4], ri[4*u +: 4], pc[u], ins);
          end
          tick();
          n_checks++;
          if (bus.retired !== (c == lat)) begin
            n_fail++;
            $display("FAIL rnd_retire: u=%0d cycle=%0d retired=%b required %b", u, c, bus.retired, (c == lat));
          end
        end
        model_cnt = (model_cnt + 1) % 65536;
        n_checks++;
        if (bus.rxOut !== 4'h0 || bus.rxIn !== 4'h0 || bus.instr_out !== 16'h0) begin
          n_fail++;
          $display("FAIL rnd_release: rxOut=%b rxIn=%b out=%h required 0 0 0000", bus.rxOut, bus.rxIn, bus.instr_out);
        end
        quiet_units();
        tick();
      end
      n_checks++;
      if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.retire_cnt !== 16'(model_cnt)) begin
        n_fail++;
        $display("FAIL rnd_idle: ins=%h ready=%b busy=%b cnt=%h required 1 0 %h", ins, bus.instr_ready, bus.busy, bus.retire_cnt, 16'(model_cnt));
      end
    end
  endtask

  // Unit 0 active while unit 2 shouts on the bus and pulses done
  task automatic test_bus_isolation();
    issue(16'h4123);
    tick();
    for (int c = 0; c < 4; c++) begin
      logic [3:0] own;
      own = 4'(1 << $urandom_range(0, 3));
      bus.unit_rxIn  = {4'h0, 4'hF, 4'h0, own};
      bus.unit_rxOut = {4'hF, 4'hF, 4'hF, 4'h0};
      bus.unit_pcInc = 4'b0100;
      bus.unit_done  = 4'b0100;
      #1;
      n_checks++;
      if (bus.rxIn !== own || bus.rxOut !== 4'h0 || bus.pcInc !== 1'b0) begin
        n_fail++;
        $display("FAIL iso_bus: rxIn=%b rxOut=%b pc=%b required %b 0000 0", bus.rxIn, bus.rxOut, bus.pcInc, own);
      end
      tick();
      n_checks++;
      if (bus.retired !== 1'b0 || bus.instr_out !== 16'h4123) begin
        n_fail++;
        $display("FAIL iso_retire: retired=%b out=%h required 0 4123", bus.retired, bus.instr_out);
      end
    end
    bus.unit_done = 4'b0001;
    tick();
    model_cnt = (model_cnt + 1) % 65536;
    quiet_units();
    tick();
    n_checks++;
    if (bus.retire_cnt !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL iso_cnt: cnt=%h required %h", bus.retire_cnt, 16'(model_cnt));
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(16'h8abc);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.instr_out !== 16'h0 || bus.retire_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_wait: ready=%b busy=%b out=%h cnt=%h required 1 0 0000 0000", bus.instr_ready, bus.busy, bus.instr_out, bus.retire_cnt);
    end
  endtask

  task automatic test_watchdog();
`ifdef SEQ_WATCHDOG_EN
    issue(16'h1abc);
    tick();
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (bus.fault !== 1'b0 || bus.instr_out !== 16'h1abc) begin
        n_fail++;
        $display("FAIL wd_wait: cycle=%0d fault=%b out=%h required 0 1abc", c, bus.fault, bus.instr_out);
      end
      tick();
    end
    n_checks++;
    if (bus.fault !== 1'b1 || bus.instr_out !== 16'h0 || bus.retired !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fault: fault=%b out=%h retired=%b required 1 0000 0", bus.fault, bus.instr_out, bus.retired);
    end
    tick();
    n_checks++;
    if (bus.fault !== 1'b0 || bus.instr_ready !== 1'b1 || bus.retire_cnt !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL wd_idle: fault=%b ready=%b cnt=%h required 0 1 %h", bus.fault, bus.instr_ready, bus.retire_cnt, 16'(model_cnt));
    end
    issue(16'h2abc);
    tick();
    for (int c = 0; c < 15; c++) tick();
    bus.unit_done = 4'b0100;
    tick();
    model_cnt = (model_cnt + 1) % 65536;
    n_checks++;
    if (bus.retired !== 1'b1 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_done_wins: retired=%b fault=%b required 1 0", bus.retired, bus.fault);
    end
    quiet_units();
    tick();
`else
    issue(16'h1abc);
    tick();
    for (int c = 0; c < 100; c++) tick();
    n_checks++;
    if (bus.instr_out !== 16'h1abc || bus.busy !== 1'b1 || bus.fault !== 1'b0 || bus.instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_hold: out=%h busy=%b fault=%b ready=%b required 1abc 1 0 0", bus.instr_out, bus.busy, bus.fault, bus.instr_ready);
    end
    bus.unit_done = 4'b0010;
    tick();
    model_cnt = (model_cnt + 1) % 65536;
    n_checks++;
    if (bus.retired !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_late_done: retired=%b required 1", bus.retired);
    end
    quiet_units();
    tick();
`endif
  endtask

  // Preload the count just below the wrap point, then retire two NOPs
  task automatic test_wrap();
    force dut.retire_cnt_q = 16'hFFFE;
    tick();
    release dut.retire_cnt_q;
    model_cnt = 32'hFFFE;
    for (int k = 0; k < 2; k++) begin
      issue(16'h0123);
      tick();
      tick();
      model_cnt = (model_cnt + 1) % 65536;
      n_checks++;
      if (bus.retire_cnt !== 16'(model_cnt)) begin
        n_fail++;
        $display("FAIL wrap_cnt: step=%0d cnt=%h required %h", k, bus.retire_cnt, 16'(model_cnt));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) unit_map[i] = -1;
    unit_map[4'h0] = -2;
    unit_map[4'h4] = 0;
    unit_map[4'h1] = 1;
    unit_map[4'h2] = 2;
    unit_map[4'h8] = 3;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    quiet_units();
    test_reset();
    test_mov();
    test_illegal();
    test_bus_isolation();
    test_random();
    test_watchdog();
    test_reset_mid_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
